// File: rtl/icmp_echo_responder_pkg.sv
// Shared ICMP constants, responder state encoding and the one's-complement
// checksum accumulate step.
package icmp_pkg;

  localparam logic [7:0] ICMP_ECHO_REQ   = 8'h08;
  localparam logic [7:0] ICMP_ECHO_REPLY = 8'h00;
  localparam int         MIN_ICMP_LEN    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CHECK,
    S_TXREQ,
    S_TX,
    S_DISCARD
  } icmp_state_e;

  // The carry out of bit 15 is folded straight back in, so the result's bit 16 stays 0.
  function automatic logic [16:0] csum_add(input logic [16:0] acc, input logic [15:0] word);
    logic [16:0] s;
    s = {1'b0, acc[15:0]} + {1'b0, word} + {16'b0, acc[16]};
    return {1'b0, s[15:0] + {15'b0, s[16]}};
  endfunction

endpackage

// File: rtl/icmp_payload_ram.sv
// Simple dual-port payload buffer: one write port, one registered read port.
module icmp_payload_ram #(
  parameter int DEPTH = 1020,
  parameter int AW    = 10
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_d, rd_data_q;

  always_comb rd_data_d = mem_q[rd_addr];

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/icmp_echo_responder.sv
// ICMP echo responder: buffers a byte-serial echo request, validates it and
// streams back an echo reply through the shared transmit arbiter.
module icmp_echo_responder
  import icmp_pkg::*;
#(
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_enable,
  input  logic [7:0]       rx_data,
  input  logic [47:0]      remote_mac,
  input  logic [31:0]      remote_ip,
  output logic             tx_request,
  input  logic             tx_enable,
  output logic             tx_active,
  output logic [7:0]       tx_data,
  output logic [15:0]      length,
  output logic [47:0]      destination_mac,
  output logic [31:0]      destination_ip,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] reply_count
);

  localparam int              AW      = $clog2(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  icmp_state_e      state_q, state_d;
  logic [15:0]      byte_no_q, byte_no_d;
  logic [7:0]       hi_q, hi_d;
  logic [16:0]      full_sum_q, full_sum_d;
  logic [16:0]      pay_sum_q, pay_sum_d;
  logic [15:0]      reply_csum_q, reply_csum_d;
  logic [15:0]      length_q, length_d;
  logic [15:0]      k_q, k_d;
  logic [47:0]      dmac_q, dmac_d;
  logic [31:0]      dip_q, dip_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] reply_q, reply_d;
  logic             rx_prev_q, rx_prev_d;

  logic             rx_rise;
  logic [1:0]       drop_inc;
  logic             reply_inc;
  logic             wr_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [7:0]       rd_data;

  icmp_payload_ram #(.DEPTH(MAX_LEN - 4), .AW(AW)) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rx_rise = rx_enable & ~rx_prev_q;
  assign wr_addr = byte_no_q[AW-1:0] - AW'(4);
  // Read one byte ahead so buffer data lines up with tx_active.
  assign rd_addr = k_q[AW-1:0] - AW'(3);

  always_comb begin
    state_d      = state_q;
    byte_no_d    = byte_no_q;
    hi_d         = hi_q;
    full_sum_d   = full_sum_q;
    pay_sum_d    = pay_sum_q;
    reply_csum_d = reply_csum_q;
    length_d     = length_q;
    k_d          = k_q;
    dmac_d       = dmac_q;
    dip_d        = dip_q;
    rx_prev_d    = rx_enable;
    drop_inc     = 2'd0;
    reply_inc    = 1'b0;
    wr_en        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A still-high rx_enable here is the tail of a message that arrived while busy.
        if (rx_rise) begin
          dmac_d     = remote_mac;
          dip_d      = remote_ip;
          byte_no_d  = 16'd1;
          hi_d       = rx_data;
          full_sum_d = '0;
          pay_sum_d  = '0;
          state_d    = (rx_data == ICMP_ECHO_REQ) ? S_HEADER : S_DISCARD;
        end
      end
      S_HEADER: begin
        if (!rx_enable) begin
          state_d  = S_IDLE;
          drop_inc = 2'd1;
        end else if (byte_no_q == 16'd1 && rx_data != 8'h00) begin
          state_d = S_DISCARD;
        end else begin
          byte_no_d = byte_no_q + 16'd1;
          if (byte_no_q[0]) full_sum_d = csum_add(full_sum_q, {hi_q, rx_data});
          else              hi_d       = rx_data;
          if (byte_no_q == 16'd3) state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!rx_enable) begin
          state_d = S_CHECK;
          if (byte_no_q[0]) begin
            full_sum_d = csum_add(full_sum_q, {hi_q, 8'h00});
            pay_sum_d  = csum_add(pay_sum_q, {hi_q, 8'h00});
          end
        end else if (byte_no_q >= 16'(MAX_LEN)) begin
          state_d  = S_DISCARD;
          drop_inc = 2'd1;
        end else begin
          wr_en     = 1'b1;
          byte_no_d = byte_no_q + 16'd1;
          if (byte_no_q[0]) begin
            full_sum_d = csum_add(full_sum_q, {hi_q, rx_data});
            pay_sum_d  = csum_add(pay_sum_q, {hi_q, rx_data});
          end else begin
            hi_d = rx_data;
          end
        end
      end
      S_CHECK: begin
        length_d = byte_no_q;
        k_d      = '0;
        if (byte_no_q < 16'(MIN_ICMP_LEN) || full_sum_q[15:0] != 16'hFFFF) begin
          state_d  = S_IDLE;
          drop_inc = 2'd1;
        end else begin
          reply_csum_d = ~pay_sum_q[15:0];
          state_d      = S_TXREQ;
        end
      end
      S_TXREQ: begin
        if (tx_enable) state_d = S_TX;
      end
      S_TX: begin
        if (k_q == length_q - 16'd1) begin
          state_d   = S_IDLE;
          reply_inc = 1'b1;
        end else begin
          k_d = k_q + 16'd1;
        end
      end
      S_DISCARD: begin
        if (!rx_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Arrivals while a reply is pending are dropped whole; CHECK may see two drops at once.
    if (rx_rise && (state_q == S_CHECK || state_q == S_TXREQ || state_q == S_TX))
      drop_inc = drop_inc + 2'd1;

    drop_d = drop_q;
    if (drop_inc != 2'd0)
      drop_d = (drop_q > CNT_MAX - CNT_W'(drop_inc)) ? CNT_MAX : drop_q + CNT_W'(drop_inc);
    reply_d = reply_q;
    if (reply_inc && reply_q != CNT_MAX) reply_d = reply_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_no_q    <= '0;
      hi_q         <= '0;
      full_sum_q   <= '0;
      pay_sum_q    <= '0;
      reply_csum_q <= '0;
      length_q     <= '0;
      k_q          <= '0;
      dmac_q       <= '0;
      dip_q        <= '0;
      drop_q       <= '0;
      reply_q      <= '0;
      rx_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_no_q    <= byte_no_d;
      hi_q         <= hi_d;
      full_sum_q   <= full_sum_d;
      pay_sum_q    <= pay_sum_d;
      reply_csum_q <= reply_csum_d;
      length_q     <= length_d;
      k_q          <= k_d;
      dmac_q       <= dmac_d;
      dip_q        <= dip_d;
      drop_q       <= drop_d;
      reply_q      <= reply_d;
      rx_prev_q    <= rx_prev_d;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (state_q == S_TX) begin
      if      (k_q == 16'd0) tx_data = ICMP_ECHO_REPLY;
      else if (k_q == 16'd1) tx_data = 8'h00;
      else if (k_q == 16'd2) tx_data = reply_csum_q[15:8];
      else if (k_q == 16'd3) tx_data = reply_csum_q[7:0];
      else                   tx_data = rd_data;
    end
  end

  assign tx_request      = (state_q == S_TXREQ);
  assign tx_active       = (state_q == S_TX);
  assign length          = length_q;
  assign destination_mac = dmac_q;
  assign destination_ip  = dip_q;
  assign drop_count      = drop_q;
  assign reply_count     = reply_q;

endmodule
